param_sync_fifo: RTL
====================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 128, data width in bits (1..1024).
REQ-002 SHALL have parameter DEPTH, default 16, entry count; power of two, 4..4096.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost-full threshold in entries (1..DEPTH-1).
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost-empty threshold in entries (1..DEPTH-1, < AF_LEVEL).
REQ-005 SHALL have parameter FWFT, default 0; 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-007 SHALL have ports: rstn  in  1  synchronous, active-low reset.
REQ-008 SHALL have ports: i_wren  in  1  write request; i_wrdata  in  DATA_W  write data.
REQ-009 SHALL have ports: i_rden  in  1  read request/pop.
REQ-010 SHALL have ports: i_clr_err  in  1  clears sticky error flags.
REQ-011 SHALL have ports: o_rddata  out  DATA_W  read data.
REQ-012 SHALL have ports: o_full, o_alm_full, o_empty, o_alm_empty  out  1 each  status flags.
REQ-013 SHALL have ports: o_count  out  $clog2(DEPTH)+1  current occupancy.
REQ-014 SHALL have ports: o_overflow, o_underflow  out  1 each  sticky error flags.

Function
REQ-015 Write accepted at edge when i_wren=1 and (count<DEPTH or read accepted same edge); i_wrdata stored at write pointer.
REQ-016 Read accepted at edge when i_rden=1 and count>0; write in same edge does not make an empty FIFO readable.
REQ-017 Both accepted same edge: count unchanged, both pointers advance (including at full).
REQ-018 Pointers $clog2(DEPTH) bits, wrap DEPTH-1 -> 0 with no gap or stall.
REQ-019 count: +1 write-only, -1 read-only, unchanged otherwise; never exceeds DEPTH or goes below 0.
REQ-020 o_count, o_full (count==DEPTH), o_empty (count==0), o_alm_full (count>=AF_LEVEL), o_alm_empty (count<=AE_LEVEL) are registered-count derived; they reflect the post-edge count, no additional latency.
REQ-021 FWFT=0: on accepted read, o_rddata loads head entry at that edge (valid cycle after i_rden); otherwise holds last value.
REQ-022 FWFT=1: o_rddata presents head entry whenever o_empty=0 (first write visible cycle after write edge); i_rden pops; value undefined-but-stable-at-last when empty (holds last popped data).
REQ-023 i_wren=1 with count==DEPTH and no accepted read: write dropped, memory unchanged, o_overflow set next edge.
REQ-024 i_rden=1 with count==0: read ignored, o_rddata held, o_underflow set next edge.
REQ-025 o_overflow/o_underflow remain 1 until i_clr_err=1 at an edge; if clear and new error coincide, flag stays 1.
REQ-026 Memory contents need no reset; only pointers, count, flags, o_rddata reset.

Reset
REQ-027 rstn=0 at rising edge: pointers=0, count=0, o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0, o_rddata=0, o_overflow=0, o_underflow=0.
REQ-028 Reset dominates all requests; i_wren/i_rden at a reset edge are ignored; reset mid-traffic discards contents.
REQ-029 First accepted operation is at first edge with rstn=1.

Verification (DATA_W=128, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2)
REQ-030 Fill: 16 writes of 0x1..0x10 from reset -> o_alm_empty drops after 3rd, o_alm_full rises after 14th, o_full=1 and o_count=16 after 16th.
REQ-031 Overflow: 17th write 0xFF at full -> dropped, o_overflow=1; 16 reads return 0x1..0x10 in order, o_empty=1; i_clr_err -> o_overflow=0.
REQ-032 Underflow/simultaneous: read on empty with write 0xA5 same edge -> o_underflow=1, o_count=1; next read returns 0xA5.
REQ-033 Full+both: at count=16, i_wren=i_rden=1 with 0x77 -> o_count stays 16, o_full stays 1, oldest word read, 0x77 later read last.
REQ-034 Wrap: 40 interleaved write/read pairs -> data order preserved across pointer wrap, o_count never >16.
REQ-035 FWFT=1 build: write 0x3C to empty -> o_rddata=0x3C next cycle without i_rden; rstn=0 mid-fill -> all REQ-027 values next cycle.

Source files
------------

// File: rtl/param_sync_fifo.sv
// Single-clock parameterised FIFO with occupancy-derived status flags, sticky
// overflow/underflow errors and a selectable registered or first-word-fall-through read port.
module param_sync_fifo #(
    parameter int DATA_W   = 128,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter bit FWFT     = 1'b0
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_wren,
    input  logic [DATA_W-1:0]        i_wrdata,
    input  logic                     i_rden,
    input  logic                     i_clr_err,
    output logic [DATA_W-1:0]        o_rddata,
    output logic                     o_full,
    output logic                     o_alm_full,
    output logic                     o_empty,
    output logic                     o_alm_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] rd_q;
    logic              rd_acc;
    logic              wr_acc;
    logic              wr_drop;
    logic              rd_drop;

    // Handshake: i_rden is a pop request taken only when the FIFO already holds data
    // before the edge; i_wren is a push request taken when there is room or when a
    // pop is taken on the same edge. Requests not taken are dropped, never stalled.
    always_comb begin
        rd_acc  = i_rden && (count != '0);
        wr_acc  = i_wren && ((count != FULL_CNT) || rd_acc);
        wr_drop = i_wren && !wr_acc;
        rd_drop = i_rden && (count == '0);
    end

    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rstn && wr_acc) begin
            mem[wr_ptr] <= i_wrdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rd_q        <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                rd_q   <= head;
            end
            if (wr_acc && !rd_acc) begin
                count <= count + CNT_W'(1);
            end else if (rd_acc && !wr_acc) begin
                count <= count - CNT_W'(1);
            end
            // A new error on the same edge as a clear wins, so no event is lost.
            if (wr_drop) begin
                o_overflow <= 1'b1;
            end else if (i_clr_err) begin
                o_overflow <= 1'b0;
            end
            if (rd_drop) begin
                o_underflow <= 1'b1;
            end else if (i_clr_err) begin
                o_underflow <= 1'b0;
            end
        end
    end

    assign o_count     = count;
    assign o_full      = (count == FULL_CNT);
    assign o_empty     = (count == '0);
    assign o_alm_full  = (count >= AF_CNT);
    assign o_alm_empty = (count <= AE_CNT);

    generate
        if (FWFT) begin : g_fwft
            // Head word shows through while occupied; the last popped word holds when empty.
            assign o_rddata = (count == '0) ? rd_q : head;
        end else begin : g_reg
            assign o_rddata = rd_q;
        end
    endgenerate

endmodule
